instr_fetch_responder: RTL and testbench

Responder side of the fetch interface. Serves 32-bit instruction fetches from the fetch stage's PC out of a byte-wide backing instruction memory, assembling four little-endian bytes per word. While a word is being assembled it raises a stall that drives the fetch stage's PC freeze. A single-entry word buffer with a tag answers a repeated fetch of the same PC without memory traffic. It sits between the fetch stage and the byte-wide instruction memory port.

---
 rtl/if_pkg.sv | 6 +
 rtl/byte_word_assembler.sv | 31 +++
 rtl/instr_fetch_responder.sv | 91 +++++++++
 tb/tb_instr_fetch_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction fetch responder
package if_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ABORT} fetch_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/byte_word_assembler.sv
// byte_word_assembler: beat counter and little-endian byte-lane register for one word
module byte_word_assembler
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic        beat,
  input  logic [7:0]  byte_in,
  output logic [1:0]  cnt,
  output logic        last_beat,
  output logic [31:0] word
);
  logic [31:0] lanes;
  assign last_beat = cnt == 2'(BYTES_PER_WORD - 1);
  // word includes the byte landing this cycle so the final beat can commit in one step
  always_comb begin
    word = lanes;
    if (load) word[{cnt, 3'b000} +: 8] = byte_in;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      lanes <= '0;
    end else begin
      cnt   <= clear ? 2'd0 : beat ? cnt + 2'd1 : cnt;
      lanes <= word;
    end
  end
endmodule

// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: serves 32-bit fetches from a byte-wide memory with a one-word tagged buffer
module instr_fetch_responder
  import if_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_stall,
  output logic              misaligned,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);
  fetch_state_t      state;
  logic [ADDR_W-1:0] tag;
  logic              tag_valid;
  logic [31:0]       word_q;
  logic [31:0]       asm_word;
  logic [1:0]        cnt;
  logic              last_beat, idle, hit, mis, start, take;
  assign idle = state == S_IDLE;
  // rst gates the decode so stall/valid drop at once even with fetch_req held high
  assign hit = rst & idle & fetch_req & tag_valid & (fetch_addr == tag);
  assign mis = rst & idle & fetch_req & (fetch_addr[1:0] != 2'b00);
  assign fetch_valid = (hit | mis) & ~flush;
  assign fetch_instr = mis ? NOP_WORD : word_q;
  assign misaligned = mis;
  assign fetch_stall = rst & (idle ? fetch_req & ~hit & ~mis & ~flush : 1'b1);
  assign start = idle & fetch_stall;
  assign take = (state == S_FETCH) & mem_ready & ~flush;
  byte_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .load      (take),
    .beat      (take),
    .byte_in   (mem_rdata),
    .cnt       (cnt),
    .last_beat (last_beat),
    .word      (asm_word)
  );
  // the committed word only changes on the final beat, so an aborted fetch leaves the buffer intact
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      tag       <= '0;
      tag_valid <= 1'b0;
      word_q    <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state    <= S_FETCH;
          mem_rd   <= 1'b1;
          mem_addr <= {fetch_addr[ADDR_W-1:2], 2'b00};
        end
        S_FETCH: if (flush) begin
          state <= mem_ready ? S_IDLE : S_ABORT;
          if (mem_ready) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
          end
        end else if (mem_ready) begin
          if (last_beat) begin
            state     <= S_IDLE;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            tag       <= {mem_addr[ADDR_W-1:2], 2'b00};
            tag_valid <= 1'b1;
            word_q    <= asm_word;
          end else mem_addr[1:0] <= cnt + 2'd1;
        end
        S_ABORT: if (mem_ready) begin
          state    <= S_IDLE;
          mem_rd   <= 1'b0;
          mem_addr <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_responder.sv
// tb_instr_fetch_responder: directed scenarios for the fetch responder
module tb_instr_fetch_responder;
  localparam int ADDR_W = 32;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fetch_req = 1'b0;
  logic              flush = 1'b0;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_valid, fetch_stall, misaligned, mem_rd;
  logic [31:0]       fetch_instr;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        mem [0:511];
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[8:0]];

  instr_fetch_responder #(.ADDR_W(ADDR_W), .NOP_WORD(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_stall (fetch_stall),
    .misaligned  (misaligned),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  task automatic test_reset();
    #3 rst = 1'b0;
    @(negedge clk);
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %0b want 0", mem_rd); end
    vectors++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 00000000", mem_addr); end
    vectors++; if (fetch_stall !== 1'b0 || fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_outputs got stall=%0b valid=%0b want 0/0", fetch_stall, fetch_valid); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    int stalls = 0;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h100; mem_ready = 1'b1;
    #1;
    if (fetch_stall) stalls++;
    vectors++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL cold_valid_early got %0b want 0", fetch_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fetch_stall) stalls++;
      vectors++; if (mem_rd !== 1'b1 || mem_addr !== 32'h100 + i) begin errors++; $display("FAIL cold_beat%0d got rd=%0b addr=%h want rd=1 addr=%h", i, mem_rd, mem_addr, 32'h100 + i); end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    if (fetch_stall) stalls++;
    vectors++; if (stalls != 5) begin errors++; $display("FAIL cold_stall_cycles got %0d want 5", stalls); end
    vectors++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h0010_0513) begin errors++; $display("FAIL cold_word got valid=%0b instr=%h want 1 00100513", fetch_valid, fetch_instr); end
  endtask

  task automatic test_hit();
    #1;
    vectors++; if (fetch_valid !== 1'b1 || fetch_stall !== 1'b0) begin errors++; $display("FAIL hit_flags got valid=%0b stall=%0b want 1/0", fetch_valid, fetch_stall); end
    vectors++; if (fetch_instr !== 32'h0010_0513) begin errors++; $display("FAIL hit_instr got %h want 00100513", fetch_instr); end
    @(negedge clk);
    vectors++; if (mem_rd !== 1'b0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL hit_no_traffic got rd=%0b valid=%0b want 0/1", mem_rd, fetch_valid); end
    fetch_req = 1'b0;
  endtask

  task automatic test_slow_memory();
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h104; mem_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++; if (mem_rd !== 1'b1 || mem_addr !== 32'h104 + c / 3 || fetch_stall !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL slow_cycle%0d got rd=%0b addr=%h stall=%0b valid=%0b want 1 %h 1 0", c, mem_rd, mem_addr, fetch_stall, fetch_valid, 32'h104 + c / 3); end
      mem_ready = (c % 3 == 2);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    vectors++; if (fetch_valid !== 1'b1 || fetch_stall !== 1'b0 || fetch_instr !== 32'hbeef_1237) begin errors++; $display("FAIL slow_done got valid=%0b stall=%0b instr=%h want 1 0 beef1237", fetch_valid, fetch_stall, fetch_instr); end
    fetch_req = 1'b0;
  endtask

  task automatic test_flush();
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h108; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    vectors++; if (mem_addr !== 32'h10a) begin errors++; $display("FAIL flush_beat2_addr got %h want 0000010a", mem_addr); end
    mem_ready = 1'b0; flush = 1'b1; fetch_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      flush = 1'b0;
      vectors++; if (mem_rd !== 1'b1 || mem_addr !== 32'h10a || fetch_stall !== 1'b1) begin errors++; $display("FAIL abort_hold%0d got rd=%0b addr=%h stall=%0b want 1 0000010a 1", c, mem_rd, mem_addr, fetch_stall); end
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    vectors++; if (mem_rd !== 1'b0 || fetch_stall !== 1'b0) begin errors++; $display("FAIL abort_exit got rd=%0b stall=%0b want 0/0", mem_rd, fetch_stall); end
    fetch_req = 1'b1; fetch_addr = 32'h104;
    #1;
    vectors++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hbeef_1237) begin errors++; $display("FAIL flush_tag_kept got valid=%0b instr=%h want 1 beef1237", fetch_valid, fetch_instr); end
    fetch_addr = 32'h108;
    #1;
    vectors++; if (fetch_valid !== 1'b0 || fetch_stall !== 1'b1) begin errors++; $display("FAIL flush_rerequest_miss got valid=%0b stall=%0b want 0/1", fetch_valid, fetch_stall); end
    flush = 1'b1;
    #1;
    vectors++; if (fetch_valid !== 1'b0 || fetch_stall !== 1'b0) begin errors++; $display("FAIL idle_flush got valid=%0b stall=%0b want 0/0", fetch_valid, fetch_stall); end
    @(negedge clk);
    flush = 1'b0; fetch_req = 1'b0;
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL idle_flush_no_start got rd=%0b want 0", mem_rd); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h10e;
    #1;
    vectors++; if (misaligned !== 1'b1 || fetch_valid !== 1'b1 || fetch_stall !== 1'b0) begin errors++; $display("FAIL mis_flags got mis=%0b valid=%0b stall=%0b want 1 1 0", misaligned, fetch_valid, fetch_stall); end
    vectors++; if (fetch_instr !== 32'h0000_0000) begin errors++; $display("FAIL mis_instr got %h want 00000000", fetch_instr); end
    @(negedge clk);
    vectors++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL mis_no_traffic got rd=%0b want 0", mem_rd); end
    fetch_req = 1'b0;
  endtask

  task automatic test_reset_mid_beat();
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h200; mem_ready = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    vectors++; if (mem_rd !== 1'b1 || mem_addr !== 32'h201) begin errors++; $display("FAIL rst_pre_beat1 got rd=%0b addr=%h want 1 00000201", mem_rd, mem_addr); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (mem_rd !== 1'b0 || fetch_stall !== 1'b0 || fetch_valid !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rst_async got rd=%0b stall=%0b valid=%0b addr=%h want 0 0 0 0", mem_rd, fetch_stall, fetch_valid, mem_addr); end
    @(negedge clk);
    rst = 1'b1; fetch_addr = 32'h100;
    #1;
    vectors++; if (fetch_valid !== 1'b0 || fetch_stall !== 1'b1) begin errors++; $display("FAIL rst_tag_cleared got valid=%0b stall=%0b want 0/1", fetch_valid, fetch_stall); end
    fetch_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    {mem[9'h103], mem[9'h102], mem[9'h101], mem[9'h100]} = 32'h0010_0513;
    {mem[9'h107], mem[9'h106], mem[9'h105], mem[9'h104]} = 32'hbeef_1237;
    {mem[9'h10b], mem[9'h10a], mem[9'h109], mem[9'h108]} = 32'hddcc_bbaa;
    {mem[9'h203], mem[9'h202], mem[9'h201], mem[9'h200]} = 32'h0403_0201;
    test_reset();
    test_cold_miss();
    test_hit();
    test_slow_memory();
    test_flush();
    test_misaligned();
    test_reset_mid_beat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
